// File: rtl/flow_region_stats.sv
// Region mean (and optional min/max with FLOW_STATS_MINMAX_EN) of a streamed
// S8.7 optical-flow field, using a shared serial restoring divider.
module flow_region_stats #(
    parameter int IMAGE_WIDTH  = 320,
    parameter int IMAGE_HEIGHT = 240,
    parameter int FLOW_WIDTH   = 16,
    parameter int BORDER       = 4,
    parameter int COORD_WIDTH  = 10,
    parameter int SUM_WIDTH    = 32,
    parameter int COUNT_WIDTH  = 20
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          frame_done,
    input  logic signed [FLOW_WIDTH-1:0]  flow_u,
    input  logic signed [FLOW_WIDTH-1:0]  flow_v,
    input  logic                          flow_valid,
    input  logic [COORD_WIDTH-1:0]        region_x_min,
    input  logic [COORD_WIDTH-1:0]        region_x_max,
    input  logic [COORD_WIDTH-1:0]        region_y_min,
    input  logic [COORD_WIDTH-1:0]        region_y_max,
    output logic                          busy,
    output logic                          stats_valid,
    output logic signed [FLOW_WIDTH-1:0]  mean_u,
    output logic signed [FLOW_WIDTH-1:0]  mean_v,
    output logic [COUNT_WIDTH-1:0]        count,
    output logic                          overrun
`ifdef FLOW_STATS_MINMAX_EN
    ,
    output logic signed [FLOW_WIDTH-1:0]  min_u,
    output logic signed [FLOW_WIDTH-1:0]  max_u,
    output logic signed [FLOW_WIDTH-1:0]  min_v,
    output logic signed [FLOW_WIDTH-1:0]  max_v
`endif
);

    localparam int PW = COORD_WIDTH + 1;
    localparam int CW = $clog2(SUM_WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        DIV_U,
        DIV_V,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [PW-1:0]                x, y;
    logic signed [SUM_WIDTH-1:0]  sum_u, sum_v;
    logic [SUM_WIDTH-1:0]         quo;
    logic [COUNT_WIDTH-1:0]       rem;
    logic [CW-1:0]                cnt;
    logic                         neg;

    logic                         beat, in_frame, in_region, take;
    logic                         div_last;
    logic [SUM_WIDTH-1:0]         abs_u, abs_v;
    logic [COUNT_WIDTH:0]         shifted;
    logic                         fits;
    logic [COUNT_WIDTH-1:0]       rem_nxt;
    logic [SUM_WIDTH-1:0]         quo_nxt;
    logic [FLOW_WIDTH-1:0]        mag;
    logic signed [FLOW_WIDTH-1:0] result;

    assign busy        = (state == ACCUM) || (state == DIV_U) || (state == DIV_V);
    assign stats_valid = (state == DONE);
    assign div_last    = (cnt == CW'(SUM_WIDTH));

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: if (start) state_nxt = ACCUM;
            ACCUM:      if (frame_done) state_nxt = DIV_U;
            DIV_U:      if (div_last) state_nxt = DIV_V;
            DIV_V:      if (div_last) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        beat      = (state == ACCUM) && flow_valid;
        in_frame  = (y < PW'(IMAGE_HEIGHT));
        in_region = (x >= PW'(region_x_min)) && (x <= PW'(region_x_max)) &&
                    (y >= PW'(region_y_min)) && (y <= PW'(region_y_max));
        take      = beat && in_frame && in_region;
    end

    // One restoring-division step on the magnitude held in quo.
    always_comb begin
        abs_u   = sum_u[SUM_WIDTH-1] ? -sum_u : sum_u;
        abs_v   = sum_v[SUM_WIDTH-1] ? -sum_v : sum_v;
        shifted = {rem, quo[SUM_WIDTH-1]};
        fits    = (shifted >= {1'b0, count});
        rem_nxt = fits ? COUNT_WIDTH'(shifted - {1'b0, count})
                       : shifted[COUNT_WIDTH-1:0];
        quo_nxt = {quo[SUM_WIDTH-2:0], fits};
        mag     = quo_nxt[FLOW_WIDTH-1:0];
        result  = (count == '0) ? '0 : (neg ? -mag : mag);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            x       <= '0;
            y       <= '0;
            sum_u   <= '0;
            sum_v   <= '0;
            count   <= '0;
            overrun <= 1'b0;
            mean_u  <= '0;
            mean_v  <= '0;
            quo     <= '0;
            rem     <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        x       <= PW'(BORDER);
                        y       <= PW'(BORDER);
                        sum_u   <= '0;
                        sum_v   <= '0;
                        count   <= '0;
                        overrun <= 1'b0;
                        mean_u  <= '0;
                        mean_v  <= '0;
                    end
                end
                ACCUM: begin
                    cnt <= '0;
                    if (beat) begin
                        if (!in_frame) begin
                            overrun <= 1'b1;
                        end else if (x == PW'(IMAGE_WIDTH - 1)) begin
                            x <= PW'(BORDER);
                            y <= y + PW'(1);
                        end else begin
                            x <= x + PW'(1);
                        end
                    end
                    if (take) begin
                        sum_u <= sum_u + {{(SUM_WIDTH-FLOW_WIDTH){flow_u[FLOW_WIDTH-1]}}, flow_u};
                        sum_v <= sum_v + {{(SUM_WIDTH-FLOW_WIDTH){flow_v[FLOW_WIDTH-1]}}, flow_v};
                        count <= count + COUNT_WIDTH'(1);
                    end
                end
                DIV_U: begin
                    // First cycle loads the settled sum; then SUM_WIDTH steps.
                    if (cnt == '0) begin
                        quo <= abs_u;
                        rem <= '0;
                        neg <= sum_u[SUM_WIDTH-1];
                        cnt <= CW'(1);
                    end else if (div_last) begin
                        mean_u <= result;
                        quo    <= abs_v;
                        rem    <= '0;
                        neg    <= sum_v[SUM_WIDTH-1];
                        cnt    <= CW'(1);
                    end else begin
                        quo <= quo_nxt;
                        rem <= rem_nxt;
                        cnt <= cnt + CW'(1);
                    end
                end
                DIV_V: begin
                    quo <= quo_nxt;
                    rem <= rem_nxt;
                    if (div_last) mean_v <= result;
                    else cnt <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef FLOW_STATS_MINMAX_EN
    logic first;

    assign first = (count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_u <= '0;
            max_u <= '0;
            min_v <= '0;
            max_v <= '0;
        end else if ((state == IDLE || state == DONE) && start) begin
            min_u <= '0;
            max_u <= '0;
            min_v <= '0;
            max_v <= '0;
        end else if (take) begin
            if (first || flow_u < min_u) min_u <= flow_u;
            if (first || flow_u > max_u) max_u <= flow_u;
            if (first || flow_v < min_v) min_v <= flow_v;
            if (first || flow_v > max_v) max_v <= flow_v;
        end
    end
`endif

endmodule
